operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
Sits directly upstream of register_block and drives its read side. Accepts one issued instruction at a time: warp id, up to three source registers, lane mask. Sequences reads over the two register-file read ports and captures per-lane operands. Presents a complete operand bundle to the execute stage with a valid/ready handshake. Yields the shared warp selector to writeback whenever writeback is active.

Parameters:
NUM_LANES, 16, lanes per warp (one bit per lane in masks/enables)
NUM_WARPS, 16, warps; WARP_W = $clog2(NUM_WARPS)
NUM_REGS, 16, registers per lane per warp; REG_W = $clog2(NUM_REGS)
DATA_W, 64, register width
TAG_W, 8, opaque instruction tag passed through unchanged

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  issue request
in_ready  out  1  collector can accept an issue
in_warp  in  WARP_W  warp id
in_rs0 / in_rs1 / in_rs2  in  REG_W each  source registers
in_nsrc  in  2  number of sources, 0..3
in_mask  in  NUM_LANES  active lanes
in_tag  in  TAG_W  pass-through tag
rf_read_en_0 / rf_read_en_1  out  NUM_LANES  per-lane read enables to register_block
rf_raddr_0 / rf_raddr_1  out  REG_W  read addresses
rf_warp_selector  out  WARP_W  warp select; a top-level mux uses it only when wb_valid=0
rf_rdata_0 / rf_rdata_1  in  NUM_LANES*DATA_W  lane-packed read data, lane k at [k*DATA_W +: DATA_W]
wb_valid  in  1  writeback owns the register file this cycle
wb_warp  in  WARP_W  writeback warp (snoop)
wb_waddr  in  REG_W  writeback register (snoop)
wb_write_en  in  NUM_LANES  writeback lane enables (snoop)
wb_wdata  in  NUM_LANES*DATA_W  writeback data (snoop)
out_valid  out  1  operand bundle valid
out_ready  in  1  execute accepts bundle
out_warp / out_mask / out_tag  out  WARP_W / NUM_LANES / TAG_W  latched instruction fields
out_opa / out_opb / out_opc  out  NUM_LANES*DATA_W each  operands for rs0 / rs1 / rs2

Behaviour:
- Register-file read is combinational. Data is valid in the same cycle as read_en and raddr. The collector captures data at the next posedge.
- FSM states: IDLE, RD01, RD2, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch warp, rs0–2, nsrc, mask and tag. Clear opa/opb/opc to 0.
  - Go to HOLD if nsrc=0, else RD01.
- RD01:
  - If wb_valid=1: all read enables are 0 and the state holds (stall).
  - Else:
    - raddr_0=rs0 and raddr_1=rs1.
    - read_en_0=mask if nsrc>=1, else 0.
    - read_en_1=mask if nsrc>=2, else 0.
    - Capture opa (and opb if nsrc>=2) at the posedge.
  - Next state: RD2 if nsrc=3, else HOLD.
- RD2:
  - If wb_valid=1: stall.
  - Else raddr_0=rs2 and read_en_0=mask; capture opc. Next state HOLD.
- HOLD:
  - out_valid=1.
  - On out_ready, go to IDLE.
  - Outputs are stable while out_valid=1 and out_ready=0.
- Capture rules: lanes with mask=0 are captured as 0 regardless of rf_rdata. Unused operands remain 0.
- rf_warp_selector = latched warp in RD01/RD2, 0 otherwise. Read enables are 0 outside RD01/RD2. Raddrs are 0 when enables are 0.
- in_ready=0 outside IDLE. Throughput is one instruction per (nsrc>=1 ? 2 : 1) + (nsrc=3) + stalls + 1 cycles.
- Latency from accept to out_valid, without stalls:
  - nsrc 0: 1 cycle.
  - nsrc 1–2: 2 cycles.
  - nsrc 3: 3 cycles.
  - Each wb_valid cycle in RD01/RD2 adds 1 cycle.
- in_mask=0 is legal: reads issue with zero enables and all operands are 0.
- rst at any cycle, including mid-RD2 or during HOLD:
  - Next state IDLE, out_valid=0, in_ready=1.
  - All rf enables, raddrs and selector are 0.
  - All latched fields and operands are 0.

Optional Feature:
OPCOL_WB_BYPASS_EN.
- Defined: in RD2 and HOLD, any wb_valid cycle with wb_warp equal to the latched warp updates the already-captured operands, which keeps them RAW-coherent.
  - Match condition: wb_waddr equals rs0/rs1/rs2 of an operand already captured.
  - Each matching operand lane with wb_write_en[k]&mask[k] is overwritten with wb_wdata lane k at the posedge.
  - In HOLD the outputs change only if out_ready=0 in that cycle.
- Undefined: snoop data ports are ignored. Only wb_valid (stall) is used.

Decomposition:
- Package opcol_pkg holds:
  - Default parameter constants.
  - Typedefs warp_t, reg_t, lane_mask_t, lane_data_t (NUM_LANES*DATA_W).
  - enum opcol_state_t {IDLE, RD01, RD2, HOLD}.
  - Function lane_zero_mask(data, mask).
- Sub-module opcol_operand_reg, instantiated three times: one operand register with clear, masked load from read data, and the optional per-lane bypass load.

Test Plan:
- Preload: register file lane k of warp w, reg r = {w,r,k}.
- Issue nsrc=2, warp 3, rs0=5, rs1=9, mask FFFF → RD01 one cycle later with selector=3, raddr 5/9, enables FFFF. out_valid 2 cycles after accept; opa lane k={3,5,k}, opb lane k={3,9,k}, opc=0.
- nsrc=3 with wb_valid high for 2 cycles during RD01 → read enables 0 on those cycles; out_valid 5 cycles after accept; opc lane k={w,rs2,k}.
- mask 00F0, nsrc=1 → read_en_0=00F0, read_en_1=0000; opa nonzero only in lanes 4–7.
- out_ready low 5 cycles in HOLD → out_valid held, in_ready=0, outputs bit-stable; in_valid pulses ignored.
- rst asserted in RD2 → next cycle IDLE, out_valid=0, in_ready=1, all rf enables 0.
- Bypass: in HOLD, wb writes warp 3 reg 5 with wb_write_en 0001 and value 0xDEAD → with OPCOL_WB_BYPASS_EN, opa lane0=0xDEAD and other lanes unchanged; without the macro, opa unchanged.

Source files
------------

// File: rtl/opcol_pkg.sv
// Shared constants, types, state encoding and helpers for the operand collector.
package opcol_pkg;

    localparam int DEF_NUM_LANES = 16;
    localparam int DEF_NUM_WARPS = 16;
    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_TAG_W     = 8;
    localparam int DEF_WARP_W    = $clog2(DEF_NUM_WARPS);
    localparam int DEF_REG_W     = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_WARP_W-1:0]               warp_t;
    typedef logic [DEF_REG_W-1:0]                reg_t;
    typedef logic [DEF_NUM_LANES-1:0]            lane_mask_t;
    typedef logic [DEF_NUM_LANES*DEF_DATA_W-1:0] lane_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD01 = 2'd1,
        RD2  = 2'd2,
        HOLD = 2'd3
    } opcol_state_t;

    function automatic lane_data_t lane_zero_mask(input lane_data_t data, input lane_mask_t mask);
        lane_data_t result;
        result = '0;
        for (int k = 0; k < DEF_NUM_LANES; k++) begin
            if (mask[k]) begin
                result[k*DEF_DATA_W +: DEF_DATA_W] = data[k*DEF_DATA_W +: DEF_DATA_W];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/opcol_operand_reg.sv
// One lane-packed operand register: clear, masked load from read data,
// and per-lane overwrite from the writeback snoop path.
module opcol_operand_reg
    import opcol_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        load,
    input  logic [NUM_LANES-1:0]        mask,
    input  logic [NUM_LANES*DATA_W-1:0] rdata,
    input  logic [NUM_LANES-1:0]        byp_we,
    input  logic [NUM_LANES*DATA_W-1:0] byp_data,
    output logic [NUM_LANES*DATA_W-1:0] q
);

    // Inactive lanes load as zero so stale register-file data never leaks out.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (load) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                q[k*DATA_W +: DATA_W] <= mask[k] ? rdata[k*DATA_W +: DATA_W] : '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (byp_we[k]) begin
                    q[k*DATA_W +: DATA_W] <= byp_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: sequences register-file reads for one issued instruction
// and hands a full operand bundle to execute. Optional macro: OPCOL_WB_BYPASS_EN.
module operand_collector
    import opcol_pkg::*;
#(
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int NUM_WARPS  = DEF_NUM_WARPS,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TAG_W      = DEF_TAG_W,
    localparam int WARP_W    = $clog2(NUM_WARPS),
    localparam int REG_W     = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WARP_W-1:0]           in_warp,
    input  logic [REG_W-1:0]            in_rs0,
    input  logic [REG_W-1:0]            in_rs1,
    input  logic [REG_W-1:0]            in_rs2,
    input  logic [1:0]                  in_nsrc,
    input  logic [NUM_LANES-1:0]        in_mask,
    input  logic [TAG_W-1:0]            in_tag,
    output logic [NUM_LANES-1:0]        rf_read_en_0,
    output logic [NUM_LANES-1:0]        rf_read_en_1,
    output logic [REG_W-1:0]            rf_raddr_0,
    output logic [REG_W-1:0]            rf_raddr_1,
    output logic [WARP_W-1:0]           rf_warp_selector,
    input  logic [NUM_LANES*DATA_W-1:0] rf_rdata_0,
    input  logic [NUM_LANES*DATA_W-1:0] rf_rdata_1,
    input  logic                        wb_valid,
    input  logic [WARP_W-1:0]           wb_warp,
    input  logic [REG_W-1:0]            wb_waddr,
    input  logic [NUM_LANES-1:0]        wb_write_en,
    input  logic [NUM_LANES*DATA_W-1:0] wb_wdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WARP_W-1:0]           out_warp,
    output logic [NUM_LANES-1:0]        out_mask,
    output logic [TAG_W-1:0]            out_tag,
    output logic [NUM_LANES*DATA_W-1:0] out_opa,
    output logic [NUM_LANES*DATA_W-1:0] out_opb,
    output logic [NUM_LANES*DATA_W-1:0] out_opc
);

    opcol_state_t state_q, state_d;

    logic [WARP_W-1:0]    warp_q;
    logic [REG_W-1:0]     rs0_q, rs1_q, rs2_q;
    logic [1:0]           nsrc_q;
    logic [NUM_LANES-1:0] mask_q;
    logic [TAG_W-1:0]     tag_q;

    logic                 accept;
    logic                 load_a, load_b, load_c;
    logic [NUM_LANES-1:0] byp_we_a, byp_we_b, byp_we_c;

    assign accept = (state_q == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            warp_q  <= '0;
            rs0_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            nsrc_q  <= '0;
            mask_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                warp_q <= in_warp;
                rs0_q  <= in_rs0;
                rs1_q  <= in_rs1;
                rs2_q  <= in_rs2;
                nsrc_q <= in_nsrc;
                mask_q <= in_mask;
                tag_q  <= in_tag;
            end
        end
    end

    // Writeback owns the register file whenever wb_valid is high, so reads stall.
    always_comb begin
        state_d          = state_q;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        rf_read_en_0     = '0;
        rf_read_en_1     = '0;
        rf_raddr_0       = '0;
        rf_raddr_1       = '0;
        rf_warp_selector = '0;
        load_a           = 1'b0;
        load_b           = 1'b0;
        load_c           = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_nsrc == 2'd0) ? HOLD : RD01;
                end
            end
            RD01: begin
                rf_warp_selector = warp_q;
                if (!wb_valid) begin
                    rf_raddr_0   = rs0_q;
                    rf_read_en_0 = mask_q;
                    load_a       = 1'b1;
                    if (nsrc_q >= 2'd2) begin
                        rf_raddr_1   = rs1_q;
                        rf_read_en_1 = mask_q;
                        load_b       = 1'b1;
                    end
                    state_d = (nsrc_q == 2'd3) ? RD2 : HOLD;
                end
            end
            RD2: begin
                rf_warp_selector = warp_q;
                if (!wb_valid) begin
                    rf_raddr_0   = rs2_q;
                    rf_read_en_0 = mask_q;
                    load_c       = 1'b1;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef OPCOL_WB_BYPASS_EN
    logic byp_active;

    // A handshake-completing HOLD cycle must not disturb the bundle being taken.
    assign byp_active = wb_valid && (wb_warp == warp_q) &&
                        ((state_q == RD2) || ((state_q == HOLD) && !out_ready));

    assign byp_we_a = (byp_active && (nsrc_q >= 2'd1) && (wb_waddr == rs0_q)) ?
                      (wb_write_en & mask_q) : '0;
    assign byp_we_b = (byp_active && (nsrc_q >= 2'd2) && (wb_waddr == rs1_q)) ?
                      (wb_write_en & mask_q) : '0;
    assign byp_we_c = (byp_active && (state_q == HOLD) && (nsrc_q == 2'd3) &&
                       (wb_waddr == rs2_q)) ? (wb_write_en & mask_q) : '0;
`else
    logic unused_snoop;

    assign unused_snoop = ^{wb_warp, wb_waddr, wb_write_en};
    assign byp_we_a     = '0;
    assign byp_we_b     = '0;
    assign byp_we_c     = '0;
`endif

    opcol_operand_reg #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W)) u_opa (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .load     (load_a),
        .mask     (mask_q),
        .rdata    (rf_rdata_0),
        .byp_we   (byp_we_a),
        .byp_data (wb_wdata),
        .q        (out_opa)
    );

    opcol_operand_reg #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W)) u_opb (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .load     (load_b),
        .mask     (mask_q),
        .rdata    (rf_rdata_1),
        .byp_we   (byp_we_b),
        .byp_data (wb_wdata),
        .q        (out_opb)
    );

    // rs2 shares read port 0 in its own cycle.
    opcol_operand_reg #(.NUM_LANES(NUM_LANES), .DATA_W(DATA_W)) u_opc (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .load     (load_c),
        .mask     (mask_q),
        .rdata    (rf_rdata_0),
        .byp_we   (byp_we_c),
        .byp_data (wb_wdata),
        .q        (out_opc)
    );

    assign out_warp = warp_q;
    assign out_mask = mask_q;
    assign out_tag  = tag_q;

endmodule

// File: tb/tb_operand_collector.sv
// Directed self-checking bench for operand_collector with a behavioural
// register file whose lane k of warp w, reg r holds {w,r,k}.
module tb_operand_collector;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_warp;
    logic [3:0]     in_rs0, in_rs1, in_rs2;
    logic [1:0]     in_nsrc;
    logic [15:0]    in_mask;
    logic [7:0]     in_tag;
    logic [15:0]    rf_read_en_0, rf_read_en_1;
    logic [3:0]     rf_raddr_0, rf_raddr_1;
    logic [3:0]     rf_warp_selector;
    logic [1023:0]  rf_rdata_0, rf_rdata_1;
    logic           wb_valid;
    logic [3:0]     wb_warp;
    logic [3:0]     wb_waddr;
    logic [15:0]    wb_write_en;
    logic [1023:0]  wb_wdata;
    logic           out_valid;
    logic           out_ready;
    logic [3:0]     out_warp;
    logic [15:0]    out_mask;
    logic [7:0]     out_tag;
    logic [1023:0]  out_opa, out_opb, out_opc;

    int checks   = 0;
    int failures = 0;

    logic [1023:0] exp_a, exp_b, exp_c;

    operand_collector dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_warp          (in_warp),
        .in_rs0           (in_rs0),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .in_nsrc          (in_nsrc),
        .in_mask          (in_mask),
        .in_tag           (in_tag),
        .rf_read_en_0     (rf_read_en_0),
        .rf_read_en_1     (rf_read_en_1),
        .rf_raddr_0       (rf_raddr_0),
        .rf_raddr_1       (rf_raddr_1),
        .rf_warp_selector (rf_warp_selector),
        .rf_rdata_0       (rf_rdata_0),
        .rf_rdata_1       (rf_rdata_1),
        .wb_valid         (wb_valid),
        .wb_warp          (wb_warp),
        .wb_waddr         (wb_waddr),
        .wb_write_en      (wb_write_en),
        .wb_wdata         (wb_wdata),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_warp         (out_warp),
        .out_mask         (out_mask),
        .out_tag          (out_tag),
        .out_opa          (out_opa),
        .out_opb          (out_opb),
        .out_opc          (out_opc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rf_val(input logic [3:0] w, input logic [3:0] r, input logic [3:0] k);
        return {52'd0, w, r, k};
    endfunction

    function automatic logic [1023:0] build_op(input logic [3:0] w, input logic [3:0] r, input logic [15:0] m);
        logic [1023:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            if (m[k]) v[k*64 +: 64] = rf_val(w, r, 4'(k));
        end
        return v;
    endfunction

    // Register file returns data on every lane; masking is the collector's job.
    always_comb begin
        rf_rdata_0 = '0;
        rf_rdata_1 = '0;
        for (int k = 0; k < 16; k++) begin
            rf_rdata_0[k*64 +: 64] = rf_val(rf_warp_selector, rf_raddr_0, 4'(k));
            rf_rdata_1[k*64 +: 64] = rf_val(rf_warp_selector, rf_raddr_1, 4'(k));
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOperand(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int lane;
        checks++;
        assert (obs === exp) else begin
            failures++;
            lane = 0;
            for (int k = 15; k >= 0; k--) begin
                if (obs[k*64 +: 64] !== exp[k*64 +: 64]) lane = k;
            end
            $error("[TB] FAIL %s lane %0d observed=%0h expected=%0h",
                   tag, lane, obs[lane*64 +: 64], exp[lane*64 +: 64]);
        end
    endtask

    // Presents one issue in IDLE; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] w, input logic [3:0] r0, input logic [3:0] r1,
                                 input logic [3:0] r2, input logic [1:0] n, input logic [15:0] m,
                                 input logic [7:0] t);
        in_warp  = w;
        in_rs0   = r0;
        in_rs1   = r1;
        in_rs2   = r2;
        in_nsrc  = n;
        in_mask  = m;
        in_tag   = t;
        in_valid = 1'b1;
        stepCycle();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_warp = '0; in_rs0 = '0; in_rs1 = '0; in_rs2 = '0;
        in_nsrc = '0; in_mask = '0; in_tag = '0; wb_valid = 1'b0; wb_warp = '0;
        wb_waddr = '0; wb_write_en = '0; wb_wdata = '0; out_ready = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_en0", 64'(rf_read_en_0), 64'd0);
        checkOutput("rst_sel", 64'(rf_warp_selector), 64'd0);
        checkOperand("rst_opa", out_opa, '0);
        rst = 1'b0;
        stepCycle();

        // nsrc=2, warp 3, rs0=5, rs1=9
        applyStimulus(4'd3, 4'd5, 4'd9, 4'd0, 2'd2, 16'hFFFF, 8'hA5);
        checkOutput("rd01_sel", 64'(rf_warp_selector), 64'd3);
        checkOutput("rd01_raddr0", 64'(rf_raddr_0), 64'd5);
        checkOutput("rd01_raddr1", 64'(rf_raddr_1), 64'd9);
        checkOutput("rd01_en0", 64'(rf_read_en_0), 64'hFFFF);
        checkOutput("rd01_en1", 64'(rf_read_en_1), 64'hFFFF);
        checkOutput("rd01_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rd01_out_valid", 64'(out_valid), 64'd0);
        stepCycle();
        exp_a = build_op(4'd3, 4'd5, 16'hFFFF);
        exp_b = build_op(4'd3, 4'd9, 16'hFFFF);
        checkOutput("n2_out_valid", 64'(out_valid), 64'd1);
        checkOperand("n2_opa", out_opa, exp_a);
        checkOperand("n2_opb", out_opb, exp_b);
        checkOperand("n2_opc", out_opc, '0);
        checkOutput("n2_warp", 64'(out_warp), 64'd3);
        checkOutput("n2_mask", 64'(out_mask), 64'hFFFF);
        checkOutput("n2_tag", 64'(out_tag), 64'hA5);
        checkOutput("hold_en0", 64'(rf_read_en_0), 64'd0);
        checkOutput("hold_sel", 64'(rf_warp_selector), 64'd0);

        // Writeback to warp 3 reg 5 lane 0 while the bundle waits in HOLD
        wb_valid = 1'b1; wb_warp = 4'd3; wb_waddr = 4'd5; wb_write_en = 16'h0001;
        wb_wdata = '0; wb_wdata[63:0] = 64'hDEAD;
        stepCycle();
        wb_valid = 1'b0; wb_write_en = '0;
`ifdef OPCOL_WB_BYPASS_EN
        exp_a[63:0] = 64'hDEAD;
`endif
        checkOperand("byp_opa", out_opa, exp_a);
        checkOperand("byp_opb", out_opb, exp_b);

        // Execute back-pressure: bundle must stay put and new issues ignored
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_warp = 4'(i + 8); in_nsrc = 2'd1; in_mask = 16'h00FF;
            #1;
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOperand("bp_opa", out_opa, exp_a);
            checkOperand("bp_opb", out_opb, exp_b);
            checkOutput("bp_warp", 64'(out_warp), 64'd3);
            stepCycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        checkOutput("release_out_valid", 64'(out_valid), 64'd0);
        checkOutput("release_in_ready", 64'(in_ready), 64'd1);

        // nsrc=3, warp 7, two writeback stall cycles in RD01
        applyStimulus(4'd7, 4'd1, 4'd2, 4'd14, 2'd3, 16'hFFFF, 8'h3C);
        wb_valid = 1'b1; wb_warp = 4'd2; wb_waddr = 4'd1;
        #1;
        checkOutput("stall1_en0", 64'(rf_read_en_0), 64'd0);
        checkOutput("stall1_en1", 64'(rf_read_en_1), 64'd0);
        checkOutput("stall1_raddr0", 64'(rf_raddr_0), 64'd0);
        stepCycle();
        checkOutput("stall2_en0", 64'(rf_read_en_0), 64'd0);
        stepCycle();
        wb_valid = 1'b0;
        #1;
        checkOutput("n3_rd01_en0", 64'(rf_read_en_0), 64'hFFFF);
        checkOutput("n3_rd01_raddr0", 64'(rf_raddr_0), 64'd1);
        checkOutput("n3_rd01_raddr1", 64'(rf_raddr_1), 64'd2);
        stepCycle();
        checkOutput("n3_rd2_raddr0", 64'(rf_raddr_0), 64'd14);
        checkOutput("n3_rd2_en0", 64'(rf_read_en_0), 64'hFFFF);
        checkOutput("n3_rd2_en1", 64'(rf_read_en_1), 64'd0);
        checkOutput("n3_rd2_out_valid", 64'(out_valid), 64'd0);
        stepCycle();
        checkOutput("n3_out_valid", 64'(out_valid), 64'd1);
        checkOperand("n3_opa", out_opa, build_op(4'd7, 4'd1, 16'hFFFF));
        checkOperand("n3_opb", out_opb, build_op(4'd7, 4'd2, 16'hFFFF));
        checkOperand("n3_opc", out_opc, build_op(4'd7, 4'd14, 16'hFFFF));
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;

        // nsrc=1, partial mask 00F0
        applyStimulus(4'd10, 4'd12, 4'd3, 4'd0, 2'd1, 16'h00F0, 8'h11);
        checkOutput("m_en0", 64'(rf_read_en_0), 64'h00F0);
        checkOutput("m_en1", 64'(rf_read_en_1), 64'd0);
        checkOutput("m_raddr0", 64'(rf_raddr_0), 64'd12);
        stepCycle();
        checkOutput("m_out_valid", 64'(out_valid), 64'd1);
        checkOperand("m_opa", out_opa, build_op(4'd10, 4'd12, 16'h00F0));
        checkOperand("m_opb", out_opb, '0);
        checkOperand("m_opc", out_opc, '0);
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;

        // nsrc=0 goes straight to HOLD
        applyStimulus(4'd1, 4'd4, 4'd4, 4'd4, 2'd0, 16'hFFFF, 8'h77);
        checkOutput("n0_out_valid", 64'(out_valid), 64'd1);
        checkOutput("n0_en0", 64'(rf_read_en_0), 64'd0);
        checkOperand("n0_opa", out_opa, '0);
        checkOutput("n0_tag", 64'(out_tag), 64'h77);
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;

        // Zero mask: reads issue with no enables, operands stay zero
        applyStimulus(4'd6, 4'd2, 4'd3, 4'd0, 2'd2, 16'h0000, 8'h01);
        checkOutput("z_en0", 64'(rf_read_en_0), 64'd0);
        checkOutput("z_sel", 64'(rf_warp_selector), 64'd6);
        stepCycle();
        checkOutput("z_out_valid", 64'(out_valid), 64'd1);
        checkOperand("z_opa", out_opa, '0);
        checkOperand("z_opb", out_opb, '0);
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;

        // Reset asserted while in RD2
        applyStimulus(4'd5, 4'd0, 4'd1, 4'd2, 2'd3, 16'hFFFF, 8'h99);
        stepCycle();
        checkOutput("r_rd2_raddr0", 64'(rf_raddr_0), 64'd2);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("r_in_ready", 64'(in_ready), 64'd1);
        checkOutput("r_out_valid", 64'(out_valid), 64'd0);
        checkOutput("r_en0", 64'(rf_read_en_0), 64'd0);
        checkOutput("r_en1", 64'(rf_read_en_1), 64'd0);
        checkOutput("r_sel", 64'(rf_warp_selector), 64'd0);
        checkOutput("r_warp", 64'(out_warp), 64'd0);
        checkOutput("r_tag", 64'(out_tag), 64'd0);
        checkOperand("r_opa", out_opa, '0);
        checkOperand("r_opb", out_opb, '0);
        stepCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
